// File: rtl/pc_mapper_pkg.sv
// Shared constants and types for the PC-side configuration mapper:
// field widths, register base addresses, program message layout and FSM states.
package pc_mapper_pkg;

  // Field widths
  localparam int NCONF       = 16;
  localparam int NREG        = 64;
  localparam int NCHAN       = 2;
  localparam int N_SF_FILTS  = 10;
  localparam int N_SF_STATE  = 27;
  localparam int N_SG_GENS   = 8;
  localparam int N_SG_PERIOD = 16;
  localparam int N_SG_TAG    = 11;
  localparam int N_TM_TIME   = 48;
  localparam int N_TM_UNIT   = 16;
  localparam int N_SG_EN     = 1 << N_SG_GENS;

  // Register base addresses
  localparam int SF_FILTS_REG       = 0;
  localparam int SF_INC_REG         = 1;
  localparam int SF_DECAY_REG       = 3;
  localparam int SG_GENS_USED_REG   = 5;
  localparam int SG_GENS_EN_REG     = 6;
  localparam int SG_GENS_EN_REGS    = N_SG_EN / NCONF;
  localparam int TM_UNIT_LEN_REG    = 22;
  localparam int TM_PC_TIME_REG     = 23;
  localparam int TM_RESET_TIME_REG  = 26;
  localparam int TM_HB_REG          = 27;
  localparam int TS_REPORT_TAGS_REG = 30;
  localparam int BD_STALL_REG       = 31;
  localparam int RESERVED_BASE_REG  = 32;

  // Channel assignment and program message length
  localparam int SG_PROG_CHAN  = 0;
  localparam int TM_STROBE_CHAN = 1;
  localparam int PROG_WORDS    = 4;

  // Program FSM: one collect state per message word, then a send state
  typedef enum logic [2:0] {
    COLLECT0,
    COLLECT1,
    COLLECT2,
    COLLECT3,
    SEND
  } prog_state_e;

  // One assembled spike-generator program write
  typedef struct packed {
    logic [N_SG_GENS-1:0]   gen_idx;
    logic [N_SG_PERIOD-1:0] period;
    logic [N_SG_PERIOD-1:0] ticks;
    logic [N_SG_TAG-1:0]    tag;
  } sg_prog_t;

endpackage

// File: rtl/pc_mapper_sg_program_assembler.sv
// Collects four channel words into one spike-generator program write and
// holds it on a valid/ack master port until the sink takes it.
module sg_program_assembler
  import pc_mapper_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             ch_v,
  input  logic [NCONF-1:0] ch_d,
  output logic             ch_a,
  output logic             prog_v,
  input  logic             prog_a,
  output sg_prog_t         prog
);

  prog_state_e state, state_nxt;
  logic        collecting;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= COLLECT0;
    else        state <= state_nxt;
  end

  // Next-state: advance one slot per accepted word, leave SEND when the sink acks
  // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT0: if (ch_v)   state_nxt = COLLECT1;
      COLLECT1: if (ch_v)   state_nxt = COLLECT2;
      COLLECT2: if (ch_v)   state_nxt = COLLECT3;
      COLLECT3: if (ch_v)   state_nxt = SEND;
      SEND:     if (prog_a) state_nxt = COLLECT0;
      default:              state_nxt = COLLECT0;
    endcase
  end

  // Outputs: accept words while collecting (never during reset), offer the write in SEND
  always_comb begin
    collecting = (state != SEND);
    ch_a       = collecting & reset;
    prog_v     = (state == SEND);
  end

  // Field registers: each accepted word lands in the slot named by the current state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prog <= '0;
    end else if (ch_v && collecting) begin
      unique case (state)
        COLLECT0: prog.gen_idx <= ch_d[N_SG_GENS-1:0];
        COLLECT1: prog.period  <= ch_d;
        COLLECT2: prog.ticks   <= ch_d;
        COLLECT3: prog.tag     <= ch_d[N_SG_TAG-1:0];
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/pc_mapper.sv
// Slices the PC-side configuration register file into per-block fields and
// turns the parser's output channels into SG program writes and time strobes.
module pc_mapper
  import pc_mapper_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NREG-1:0][NCONF-1:0]        conf_reg_out,
  input  logic [NCHAN-1:0]                  conf_channel_v,
  input  logic [NCHAN-1:0][NCONF-1:0]       conf_channel_d,
  output logic [NCHAN-1:0]                  conf_channel_a,
  output logic [N_SF_FILTS-1:0]             sf_filts_used,
  output logic [N_SF_STATE-1:0]             sf_increment_constant,
  output logic [N_SF_STATE-1:0]             sf_decay_constant,
  output logic [N_SG_GENS-1:0]              sg_gens_used,
  output logic [N_SG_EN-1:0]                sg_gens_en,
  output logic [N_SG_GENS-1:0]              sg_prog_gen_idx,
  output logic [N_SG_PERIOD-1:0]            sg_prog_period,
  output logic [N_SG_PERIOD-1:0]            sg_prog_ticks,
  output logic [N_SG_TAG-1:0]               sg_prog_tag,
  output logic                              sg_prog_v,
  input  logic                              sg_prog_a,
  output logic [N_TM_UNIT-1:0]              tm_unit_len,
  output logic [N_TM_TIME-1:0]              tm_pc_time_elapsed,
  output logic [N_TM_TIME-1:0]              tm_send_hb_up_every,
  output logic                              tm_reset_time,
  output logic                              ts_report_tags,
  output logic                              bd_stall_up,
  output logic                              bd_stall_dn
);

  sg_prog_t prog;
  logic     prog_ch_a;
  logic     time_strobe;

  sg_program_assembler u_sg_program_assembler (
    .clk    (clk),
    .reset  (reset),
    .ch_v   (conf_channel_v[SG_PROG_CHAN]),
    .ch_d   (conf_channel_d[SG_PROG_CHAN]),
    .ch_a   (prog_ch_a),
    .prog_v (sg_prog_v),
    .prog_a (sg_prog_a),
    .prog   (prog)
  );

  assign sg_prog_gen_idx = prog.gen_idx;
  assign sg_prog_period  = prog.period;
  assign sg_prog_ticks   = prog.ticks;
  assign sg_prog_tag     = prog.tag;

  // The strobe channel always accepts outside reset
  assign conf_channel_a = {reset, prog_ch_a};

  // Register-file slices: zero latency, multi-register fields low word first
  always_comb begin
    sf_filts_used         = conf_reg_out[SF_FILTS_REG][N_SF_FILTS-1:0];
    sf_increment_constant = {conf_reg_out[SF_INC_REG+1][N_SF_STATE-NCONF-1:0], conf_reg_out[SF_INC_REG]};
    sf_decay_constant     = {conf_reg_out[SF_DECAY_REG+1][N_SF_STATE-NCONF-1:0], conf_reg_out[SF_DECAY_REG]};
    sg_gens_used          = conf_reg_out[SG_GENS_USED_REG][N_SG_GENS-1:0];
    sg_gens_en            = conf_reg_out[SG_GENS_EN_REG+SG_GENS_EN_REGS-1:SG_GENS_EN_REG];
    tm_unit_len           = conf_reg_out[TM_UNIT_LEN_REG];
    tm_pc_time_elapsed    = conf_reg_out[TM_PC_TIME_REG+2:TM_PC_TIME_REG];
    tm_send_hb_up_every   = conf_reg_out[TM_HB_REG+2:TM_HB_REG];
    tm_reset_time         = conf_reg_out[TM_RESET_TIME_REG][0] | time_strobe;
    ts_report_tags        = conf_reg_out[TS_REPORT_TAGS_REG][0];
    bd_stall_up           = conf_reg_out[BD_STALL_REG][0];
    bd_stall_dn           = conf_reg_out[BD_STALL_REG][1];
  end

  // One-cycle reset_time pulse for every accepted strobe word with bit 0 set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) time_strobe <= 1'b0;
    else        time_strobe <= conf_channel_v[TM_STROBE_CHAN] & conf_channel_d[TM_STROBE_CHAN][0];
  end

  // Reserved registers and unused upper bits are deliberately ignored
  logic unused_bits;
  assign unused_bits = ^{conf_reg_out[NREG-1:RESERVED_BASE_REG],
                         conf_reg_out[SF_FILTS_REG][NCONF-1:N_SF_FILTS],
                         conf_reg_out[SF_INC_REG+1][NCONF-1:N_SF_STATE-NCONF],
                         conf_reg_out[SF_DECAY_REG+1][NCONF-1:N_SF_STATE-NCONF],
                         conf_reg_out[SG_GENS_USED_REG][NCONF-1:N_SG_GENS],
                         conf_reg_out[TM_RESET_TIME_REG][NCONF-1:1],
                         conf_reg_out[TS_REPORT_TAGS_REG][NCONF-1:1],
                         conf_reg_out[BD_STALL_REG][NCONF-1:2],
                         conf_channel_d[TM_STROBE_CHAN][NCONF-1:1]};

endmodule

// File: tb/tb_pc_mapper.sv
// Self-checking bench for pc_mapper: directed literal cases followed by a
// randomized run compared every cycle against a word-counting reference model.
module tb_pc_mapper;
  import pc_mapper_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0]                   regs [NREG];
  logic [NREG-1:0][NCONF-1:0]    conf_reg_out;
  logic [NCHAN-1:0]              ch_v;
  logic [NCHAN-1:0][NCONF-1:0]   ch_d;
  logic [NCHAN-1:0]              ch_a;
  logic [N_SF_FILTS-1:0]         sf_filts_used;
  logic [N_SF_STATE-1:0]         sf_increment_constant, sf_decay_constant;
  logic [N_SG_GENS-1:0]          sg_gens_used;
  logic [N_SG_EN-1:0]            sg_gens_en;
  logic [N_SG_GENS-1:0]          sg_prog_gen_idx;
  logic [N_SG_PERIOD-1:0]        sg_prog_period, sg_prog_ticks;
  logic [N_SG_TAG-1:0]           sg_prog_tag;
  logic                          sg_prog_v, prog_a;
  logic [N_TM_UNIT-1:0]          tm_unit_len;
  logic [N_TM_TIME-1:0]          tm_pc_time_elapsed, tm_send_hb_up_every;
  logic                          tm_reset_time, ts_report_tags, bd_stall_up, bd_stall_dn;

  always_comb for (int i = 0; i < NREG; i++) conf_reg_out[i] = regs[i];

  pc_mapper dut (
    .clk                   (clk),
    .reset                 (reset),
    .conf_reg_out          (conf_reg_out),
    .conf_channel_v        (ch_v),
    .conf_channel_d        (ch_d),
    .conf_channel_a        (ch_a),
    .sf_filts_used         (sf_filts_used),
    .sf_increment_constant (sf_increment_constant),
    .sf_decay_constant     (sf_decay_constant),
    .sg_gens_used          (sg_gens_used),
    .sg_gens_en            (sg_gens_en),
    .sg_prog_gen_idx       (sg_prog_gen_idx),
    .sg_prog_period        (sg_prog_period),
    .sg_prog_ticks         (sg_prog_ticks),
    .sg_prog_tag           (sg_prog_tag),
    .sg_prog_v             (sg_prog_v),
    .sg_prog_a             (prog_a),
    .tm_unit_len           (tm_unit_len),
    .tm_pc_time_elapsed    (tm_pc_time_elapsed),
    .tm_send_hb_up_every   (tm_send_hb_up_every),
    .tm_reset_time         (tm_reset_time),
    .ts_report_tags        (ts_report_tags),
    .bd_stall_up           (bd_stall_up),
    .bd_stall_dn           (bd_stall_dn)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts accepted channel-0 words; four make a pending write
  int          m_held_n  = 0;
  bit          m_sending = 0;
  bit          m_pulse   = 0;
  logic [15:0] m_words [PROG_WORDS];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_held_n  = 0;
      m_sending = 0;
      m_pulse   = 0;
    end else begin
      m_pulse = ch_v[1] && ch_d[1][0];
      if (m_sending) begin
        if (prog_a) m_sending = 0;
      end else if (ch_v[0]) begin
        m_words[m_held_n] = ch_d[0];
        m_held_n = m_held_n + 1;
        if (m_held_n == PROG_WORDS) begin
          m_held_n  = 0;
          m_sending = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge
  always @(negedge clk) begin : compare
    logic [255:0]    e_en;
    longint unsigned e_pc, e_hb;
    for (int k = 0; k < N_SG_EN; k++) e_en[k] = ((regs[SG_GENS_EN_REG + k / 16] >> (k % 16)) & 16'd1) != 0;
    e_pc = (64'(regs[25]) << 32) + (64'(regs[24]) << 16) + 64'(regs[23]);
    e_hb = (64'(regs[29]) << 32) + (64'(regs[28]) << 16) + 64'(regs[27]);
    check("ch0_ack", ch_a[0], reset && !m_sending);
    check("ch1_ack", ch_a[1], reset);
    check("prog_v", sg_prog_v, m_sending);
    if (m_sending) begin
      check("prog_gen_idx", sg_prog_gen_idx, m_words[0] % 256);
      check("prog_period", sg_prog_period, m_words[1]);
      check("prog_ticks", sg_prog_ticks, m_words[2]);
      check("prog_tag", sg_prog_tag, m_words[3] % 2048);
    end
    check("reset_time", tm_reset_time, m_pulse || (regs[26] % 2 == 1));
    check("filts_used", sf_filts_used, regs[0] % 1024);
    check("inc_const", sf_increment_constant, 64'(regs[2] % 2048) * 65536 + 64'(regs[1]));
    check("decay_const", sf_decay_constant, 64'(regs[4] % 2048) * 65536 + 64'(regs[3]));
    check("gens_used", sg_gens_used, regs[5] % 256);
    check("gens_en", sg_gens_en, e_en);
    check("unit_len", tm_unit_len, regs[22]);
    check("pc_time", tm_pc_time_elapsed, e_pc);
    check("hb_every", tm_send_hb_up_every, e_hb);
    check("report_tags", ts_report_tags, regs[30] % 2);
    check("stall_up", bd_stall_up, regs[31] % 2);
    check("stall_dn", bd_stall_dn, (regs[31] / 2) % 2);
  end

  // Offer one word on channel 0 until it is taken, bounded
  task automatic send_word0(input logic [15:0] w);
    int budget = 50;
    bit got = 0;
    ch_v[0] = 1'b1;
    ch_d[0] = w;
    while (!got && budget > 0) begin
      @(negedge clk);
      got = ch_a[0];
      @(posedge clk); #2;
      budget--;
    end
    ch_v[0] = 1'b0;
    if (!got) check("ch0_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_msg(input logic [15:0] w0, w1, w2, w3);
    send_word0(w0);
    send_word0(w1);
    send_word0(w2);
    send_word0(w3);
  endtask

  initial begin : stim
    logic [255:0] e_lit;
    reset = 1'b1;
    for (int i = 0; i < NREG; i++) regs[i] = '0;
    ch_v = '0;
    ch_d = '0;
    prog_a = 1'b1;
    #1 reset = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ch0_ack", ch_a[0], 1'b0);
    check("rst_ch1_ack", ch_a[1], 1'b0);
    check("rst_prog_v", sg_prog_v, 1'b0);
    check("rst_reset_time", tm_reset_time, 1'b0);
    @(posedge clk); #2 reset = 1'b1;

    // Zero-latency register slicing
    regs[0] = 16'h03FF; regs[1] = 16'hFFFF; regs[2] = 16'h07FF;
    #1;
    check("lit_filts_used", sf_filts_used, 10'd1023);
    check("lit_inc_const", sf_increment_constant, 27'h7FFFFFF);
    regs[6] = 16'h0001; regs[21] = 16'h8000;
    #1;
    e_lit = '0; e_lit[0] = 1'b1; e_lit[255] = 1'b1;
    check("lit_gens_en", sg_gens_en, e_lit);

    // Program message, sink acks immediately: v high for exactly one cycle
    @(posedge clk); #2;
    send_msg(16'h0005, 16'h0100, 16'h0020, 16'h07FF);
    @(negedge clk);
    check("lit_v_high", sg_prog_v, 1'b1);
    check("lit_gen_idx", sg_prog_gen_idx, 8'd5);
    check("lit_period", sg_prog_period, 16'h0100);
    check("lit_ticks", sg_prog_ticks, 16'h0020);
    check("lit_tag", sg_prog_tag, 11'h7FF);
    @(negedge clk);
    check("lit_v_one_cycle", sg_prog_v, 1'b0);

    // Same message with the sink stalled: write held, no further word taken
    @(posedge clk); #2 prog_a = 1'b0;
    send_msg(16'h0005, 16'h0100, 16'h0020, 16'h07FF);
    ch_v[0] = 1'b1;
    ch_d[0] = 16'hAAAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("lit_stall_v", sg_prog_v, 1'b1);
      check("lit_stall_ack0", ch_a[0], 1'b0);
      check("lit_stall_gen_idx", sg_prog_gen_idx, 8'd5);
      check("lit_stall_tag", sg_prog_tag, 11'h7FF);
    end
    @(posedge clk); #2;
    ch_v[0] = 1'b0;
    prog_a = 1'b1;
    @(negedge clk);
    check("lit_stall_release_v", sg_prog_v, 1'b1);
    @(negedge clk);
    check("lit_stall_done_v", sg_prog_v, 1'b0);

    // Time strobe: d[0]=1 pulses for one cycle, d[0]=0 does nothing
    @(posedge clk); #2;
    ch_v[1] = 1'b1; ch_d[1] = 16'h0001;
    @(posedge clk); #2 ch_v[1] = 1'b0;
    @(negedge clk); check("lit_strobe_hi", tm_reset_time, 1'b1);
    @(negedge clk); check("lit_strobe_lo", tm_reset_time, 1'b0);
    @(posedge clk); #2;
    ch_v[1] = 1'b1; ch_d[1] = 16'h0000;
    @(posedge clk); #2 ch_v[1] = 1'b0;
    @(negedge clk); check("lit_strobe_none", tm_reset_time, 1'b0);

    // Reset mid-message discards the partial collection
    send_word0(16'h0011);
    send_word0(16'h2222);
    reset = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    send_msg(16'h0009, 16'h1234, 16'h5678, 16'hF923);
    @(negedge clk);
    check("lit_post_rst_v", sg_prog_v, 1'b1);
    check("lit_post_rst_gen_idx", sg_prog_gen_idx, 8'd9);
    check("lit_post_rst_period", sg_prog_period, 16'h1234);
    check("lit_post_rst_ticks", sg_prog_ticks, 16'h5678);
    check("lit_post_rst_tag", sg_prog_tag, 11'h123);

    // Randomized traffic on both channels, sink backpressure, register churn, rare resets
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      ch_v[0] = ($urandom % 4) != 0;
      ch_d[0] = 16'($urandom);
      ch_v[1] = ($urandom % 4) == 0;
      ch_d[1] = 16'($urandom);
      prog_a  = ($urandom % 3) != 0;
      if ($urandom % 8 == 0) regs[$urandom % NREG] = 16'($urandom);
      reset = ($urandom % 200) != 0;
    end
    @(posedge clk); #2;
    reset = 1'b1;
    ch_v  = '0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
